// File: rtl/ping_tdoa_capture.sv
// ping_tdoa_capture: timestamps the first rising edge on each of three hydrophone
// detector lines relative to the earliest arrival and hands the relative arrival
// times to the triangulation stage over a valid/ready handshake.
module ping_tdoa_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [2:0]       hit,
    output logic             busy,
    output logic             tdoa_valid,
    input  logic             tdoa_ready,
    output logic [CNT_W-1:0] t_rel0,
    output logic [CNT_W-1:0] t_rel1,
    output logic [CNT_W-1:0] t_rel2,
    output logic [2:0]       hit_mask,
    output logic [1:0]       first_idx,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Last counter value at which the capture window is still open.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    // Stamp reported for a channel that never arrived.
    localparam logic [CNT_W-1:0] NO_STAMP = '1;

    state_t           state_q, state_d;
    logic [2:0]       hit_q, hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] t_rel_q [0:2];
    logic [CNT_W-1:0] t_rel_d [0:2];
    logic [2:0]       mask_q, mask_d;
    logic [1:0]       first_idx_q, first_idx_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic [2:0]       edge_det;
    logic [2:0]       new_hits;

    // Lowest-numbered channel among a set of simultaneous arrivals.
    function automatic logic [1:0] lowest_idx(input logic [2:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    // Next-state and capture datapath.
    always_comb begin
        state_d     = state_q;
        hit_d       = hit;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        first_idx_d = first_idx_q;
        timeout_d   = timeout_q;
        for (int i = 0; i < 3; i++) t_rel_d[i] = t_rel_q[i];

        // A line already high when sampled previously is not a new arrival.
        edge_det = hit & ~hit_q;
        new_hits = 3'b000;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d     = ARMED;
                    cnt_d       = '0;
                    mask_d      = 3'b000;
                    first_idx_d = 2'd0;
                    timeout_d   = 1'b0;
                    for (int i = 0; i < 3; i++) t_rel_d[i] = '0;
                end
            end
            ARMED: begin
                if (|edge_det) begin
                    // Earliest arrivals define time zero; their stamps stay at 0.
                    mask_d      = edge_det;
                    first_idx_d = lowest_idx(edge_det);
                    cnt_d       = CNT_W'(1);
                    state_d     = (edge_det == 3'b111) ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                new_hits = edge_det & ~mask_q;
                for (int i = 0; i < 3; i++) begin
                    if (new_hits[i]) t_rel_d[i] = cnt_q;
                end
                mask_d = mask_q | new_hits;
                if (mask_d == 3'b111) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Window closed: mark missing channels and hold the counter.
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        if (!mask_d[i]) t_rel_d[i] = NO_STAMP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (tdoa_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d == ARMED) || (state_d == CAPTURE);
        valid_d = (state_d == DONE);
    end

    // State, edge-detect history, stamps and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hit_q       <= 3'b000;
            cnt_q       <= '0;
            mask_q      <= 3'b000;
            first_idx_q <= 2'd0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            for (int i = 0; i < 3; i++) t_rel_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            hit_q       <= hit_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            first_idx_q <= first_idx_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            for (int i = 0; i < 3; i++) t_rel_q[i] <= t_rel_d[i];
        end
    end

    assign busy       = busy_q;
    assign tdoa_valid = valid_q;
    assign t_rel0     = t_rel_q[0];
    assign t_rel1     = t_rel_q[1];
    assign t_rel2     = t_rel_q[2];
    assign hit_mask   = mask_q;
    assign first_idx  = first_idx_q;
    assign timeout    = timeout_q;

endmodule
